xpe_layer_seq: RTL and testbench

Per-layer sequencer in front of the xpe post-processing datapath. It accepts one layer command at a time and, when the command requests it, loads the 16-entry activation LUT from a word stream. It then holds a stable xpe configuration with calc enable asserted until the programmed number of output vectors has appeared on the xpe valid, drains the pipeline, and pulses a done flag. It sits between the npu_core layer controller and xpe.

---
 rtl/npu_xpe_pkg.sv | 26 ++
 rtl/xpe_lut_writer.sv | 48 ++++
 rtl/xpe_layer_seq.sv | 161 ++++++++++++++++
 tb/tb_xpe_layer_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_xpe_pkg.sv
// Shared xpe definitions: sequencer state encoding,
// layer mode codes and activation selects.
package npu_xpe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LUT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } xpe_state_e;

    localparam logic [3:0] MODE_CONV     = 4'd1;
    localparam logic [3:0] MODE_FC       = 4'd2;
    localparam logic [3:0] MODE_ADD      = 4'd3;
    localparam logic [3:0] MODE_POOL     = 4'd4;
    localparam logic [3:0] MODE_AVG_POOL = 4'd5;
    localparam logic [3:0] MODE_MATRIX   = 4'd6;
    localparam logic [3:0] MODE_DOTACC   = 4'd8;

    localparam logic [1:0] NOACT   = 2'd0;
    localparam logic [1:0] RELU    = 2'd1;
    localparam logic [1:0] SIGMOID = 2'd2;
    localparam logic [1:0] TANH    = 2'd3;

endpackage

// File: rtl/xpe_lut_writer.sv
// Activation LUT loader: registers each accepted word
// onto the LUT write port and signals a full table.
module xpe_lut_writer #(
    parameter int LUT_DEPTH = 16,
    parameter int DW        = 24,
    parameter int AW        = $clog2(LUT_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_wr,
    input  logic [DW-1:0] i_dat,
    output logic          o_done,
    output logic [DW-1:0] o_lut_wdata,
    output logic [AW-1:0] o_lut_addr,
    output logic          o_lut_we,
    output logic          o_lut_en
);

    localparam int IW = AW + 1;
    localparam logic [IW-1:0] IDX_FULL = IW'(LUT_DEPTH);

    logic [IW-1:0] idx;

    // Extra index bit lets the counter reach DEPTH without wrapping.
    assign o_done = (idx == IDX_FULL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx         <= '0;
            o_lut_wdata <= '0;
            o_lut_addr  <= '0;
            o_lut_we    <= 1'b0;
            o_lut_en    <= 1'b0;
        end else begin
            o_lut_we <= i_wr;
            o_lut_en <= i_wr;
            if (i_start) begin
                idx <= '0;
            end else if (i_wr) begin
                idx         <= idx + 1'b1;
                o_lut_addr  <= idx[AW-1:0];
                o_lut_wdata <= i_dat;
            end
        end
    end

endmodule

// File: rtl/xpe_layer_seq.sv
// Per-layer sequencer for xpe: accepts a layer command, optionally
// loads the activation LUT, runs until out_cnt valids, drains, done.
module xpe_layer_seq
    import npu_xpe_pkg::*;
#(
    parameter int OUT_CNT_WIDTH = 16,
    parameter int DRAIN_CYCLES  = 8,
    parameter int LUT_DEPTH     = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_vld,
    output logic                     o_cmd_rdy,
    input  logic [3:0]               i_cmd_mode,
    input  logic [1:0]               i_cmd_xpe_mode,
    input  logic                     i_cmd_actfun_en,
    input  logic                     i_cmd_dotacc_en,
    input  logic [11:0]              i_cmd_q_encode,
    input  logic [OUT_CNT_WIDTH-1:0] i_cmd_out_cnt,
    input  logic                     i_cmd_lut_load,
    input  logic                     i_lut_vld,
    input  logic [23:0]              i_lut_dat,
    output logic                     o_lut_rdy,
    output logic [3:0]               o_mode,
    output logic [1:0]               o_xpe_mode,
    output logic                     o_actfun_en,
    output logic                     o_dotacc_en,
    output logic [3:0]               o_i_q_encode,
    output logic [3:0]               o_w_q_encode,
    output logic [3:0]               o_o_q_encode,
    output logic                     o_calc_en,
    output logic [23:0]              o_lut_wdata,
    output logic [3:0]               o_lut_addr,
    output logic                     o_lut_we,
    output logic                     o_lut_en,
    input  logic                     i_xpe_dat_vld,
    output logic                     o_busy,
    output logic                     o_layer_done,
    output logic                     o_err
);

    localparam int CW = OUT_CNT_WIDTH;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    xpe_state_e    state;
    logic [CW-1:0] out_cnt_q;
    logic [CW-1:0] out_count;
    logic [DW-1:0] drain_cnt;
    logic          cmd_fire;
    logic          lut_wr;
    logic          lut_done;
    logic          vld_stray;

    // Ready drops once the table is full so no 17th word is consumed.
    assign o_cmd_rdy = (state == ST_IDLE);
    assign o_lut_rdy = (state == ST_LUT) && !lut_done;
    assign cmd_fire  = i_cmd_vld && o_cmd_rdy;
    assign lut_wr    = i_lut_vld && o_lut_rdy;
    assign vld_stray = i_xpe_dat_vld && (state == ST_IDLE ||
                       state == ST_LUT || state == ST_DRAIN);

    xpe_lut_writer #(
        .LUT_DEPTH (LUT_DEPTH),
        .DW        (24),
        .AW        (4)
    ) u_lut_writer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (cmd_fire),
        .i_wr        (lut_wr),
        .i_dat       (i_lut_dat),
        .o_done      (lut_done),
        .o_lut_wdata (o_lut_wdata),
        .o_lut_addr  (o_lut_addr),
        .o_lut_we    (o_lut_we),
        .o_lut_en    (o_lut_en)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            out_cnt_q    <= '0;
            out_count    <= '0;
            drain_cnt    <= '0;
            o_mode       <= '0;
            o_xpe_mode   <= '0;
            o_actfun_en  <= 1'b0;
            o_dotacc_en  <= 1'b0;
            o_i_q_encode <= '0;
            o_w_q_encode <= '0;
            o_o_q_encode <= '0;
            o_calc_en    <= 1'b0;
            o_busy       <= 1'b0;
            o_layer_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_layer_done <= 1'b0;
            if (vld_stray) o_err <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        o_mode       <= i_cmd_mode;
                        o_xpe_mode   <= i_cmd_xpe_mode;
                        o_actfun_en  <= i_cmd_actfun_en;
                        o_dotacc_en  <= i_cmd_dotacc_en;
                        o_i_q_encode <= i_cmd_q_encode[11:8];
                        o_w_q_encode <= i_cmd_q_encode[7:4];
                        o_o_q_encode <= i_cmd_q_encode[3:0];
                        out_cnt_q    <= i_cmd_out_cnt;
                        out_count    <= '0;
                        drain_cnt    <= '0;
                        o_err        <= 1'b0;
                        o_busy       <= 1'b1;
                        if (i_cmd_lut_load) begin
                            state <= ST_LUT;
                        end else if (i_cmd_out_cnt != '0) begin
                            state     <= ST_RUN;
                            o_calc_en <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_LUT: begin
                    if (lut_done) begin
                        if (out_cnt_q != '0) begin
                            state     <= ST_RUN;
                            o_calc_en <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_xpe_dat_vld) begin
                        out_count <= out_count + 1'b1;
                        if (out_count + 1'b1 == out_cnt_q) begin
                            state     <= ST_DRAIN;
                            o_calc_en <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state        <= ST_DONE;
                        o_layer_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xpe_layer_seq.sv
// Scoreboard bench for xpe_layer_seq: LUT writes checked from a
// queue, layer latencies checked against bench-side cycle stamps.
module tb_xpe_layer_seq;
    import npu_xpe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [3:0]  cmd_mode = '0;
    logic [1:0]  cmd_xmode = '0;
    logic        cmd_act = 1'b0;
    logic        cmd_dot = 1'b0;
    logic [11:0] cmd_q = '0;
    logic [15:0] cmd_ocnt = '0;
    logic        cmd_lutl = 1'b0;
    logic        lut_vld = 1'b0;
    logic [23:0] lut_dat = '0;
    logic        lut_rdy;
    logic [3:0]  mode;
    logic [1:0]  xmode;
    logic        act_en, dot_en;
    logic [3:0]  iq, wq, oq;
    logic        calc_en;
    logic [23:0] lut_wdata;
    logic [3:0]  lut_addr;
    logic        lut_we, lut_en;
    logic        dat_vld = 1'b0;
    logic        busy, done, err;

    xpe_layer_seq dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_cmd_vld       (cmd_vld),
        .o_cmd_rdy       (cmd_rdy),
        .i_cmd_mode      (cmd_mode),
        .i_cmd_xpe_mode  (cmd_xmode),
        .i_cmd_actfun_en (cmd_act),
        .i_cmd_dotacc_en (cmd_dot),
        .i_cmd_q_encode  (cmd_q),
        .i_cmd_out_cnt   (cmd_ocnt),
        .i_cmd_lut_load  (cmd_lutl),
        .i_lut_vld       (lut_vld),
        .i_lut_dat       (lut_dat),
        .o_lut_rdy       (lut_rdy),
        .o_mode          (mode),
        .o_xpe_mode      (xmode),
        .o_actfun_en     (act_en),
        .o_dotacc_en     (dot_en),
        .o_i_q_encode    (iq),
        .o_w_q_encode    (wq),
        .o_o_q_encode    (oq),
        .o_calc_en       (calc_en),
        .o_lut_wdata     (lut_wdata),
        .o_lut_addr      (lut_addr),
        .o_lut_we        (lut_we),
        .o_lut_en        (lut_en),
        .i_xpe_dat_vld   (dat_vld),
        .o_busy          (busy),
        .o_layer_done    (done),
        .o_err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [23:0] dat;
    } lut_exp_t;

    lut_exp_t sb[$];
    lut_exp_t e;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int we_cnt = 0;
    int first_we = -1;
    int last_we = -1;
    int calc_rise = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    logic calc_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (lut_we) begin
            if (we_cnt == 0) first_we = cyc;
            last_we = cyc;
            we_cnt++;
            chk("lut_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("lut_addr", 32'(lut_addr), 32'(e.addr));
                chk("lut_dat", 32'(lut_wdata), 32'(e.dat));
                chk("lut_en", 32'(lut_en), 1);
            end
        end
        if (calc_en && !calc_q) calc_rise = cyc;
        calc_q = calc_en;
        if (done) begin
            done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] m,
                            input logic [1:0] xm,
                            input logic a, input logic d,
                            input logic [11:0] q,
                            input logic [15:0] oc,
                            input logic ll,
                            output int acc);
        int t = 0;
        while (busy && t < 200) begin
            tick();
            t++;
        end
        chk("idle_wait", 32'(busy), 0);
        cmd_mode  = m;
        cmd_xmode = xm;
        cmd_act   = a;
        cmd_dot   = d;
        cmd_q     = q;
        cmd_ocnt  = oc;
        cmd_lutl  = ll;
        cmd_vld   = 1'b1;
        acc       = cyc;
        tick();
        cmd_vld   = 1'b0;
    endtask

    task automatic stream_lut(input int n, input bit tog,
                              input logic [23:0] base);
        int  i = 0;
        int  t = 0;
        bit  fire;
        while (i < n && t < 200) begin
            lut_vld = tog ? (t % 2 == 0) : 1'b1;
            lut_dat = base + 24'(i);
            fire = lut_vld && lut_rdy;
            if (fire) sb.push_back('{4'(i), base + 24'(i)});
            tick();
            if (fire) i++;
            t++;
        end
        lut_vld = 1'b0;
        chk("lut_stream", i, n);
    endtask

    task automatic pulse_vld(output int c);
        dat_vld = 1'b1;
        c = cyc;
        tick();
        dat_vld = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (done_cnt == prev && t < 100) begin
            tick();
            t++;
        end
        chk("done_seen", done_cnt, prev + 1);
    endtask

    task automatic clr_mon();
        we_cnt    = 0;
        first_we  = -1;
        last_we   = -1;
        calc_rise = -1;
    endtask

    initial begin
        int acc, v, v2, dc;
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, v, v2, dc;
        repeat (3) tick();
        chk("rst_outs", {mode, xmode, act_en, dot_en, iq, wq, oq,
                         calc_en, lut_we, lut_en, busy, done, err}, 0);
        chk("rst_lut", {lut_wdata, lut_addr}, 0);
        chk("rst_rdy", {cmd_rdy, lut_rdy}, 2'b10);
        rst_n = 1'b1;
        tick();
        chk("rdy_rel", 32'(cmd_rdy), 1);

        // Plain conv layer, 4 valids spaced by 3 cycles
        clr_mon();
        dc = done_cnt;
        send_cmd(MODE_CONV, RELU, 1, 0, 12'h321, 16'd4, 0, acc);
        for (int k = 0; k < 4; k++) begin
            repeat (2) tick();
            pulse_vld(v);
        end
        chk("calc_fall", 32'(calc_en), 0);
        wait_done(dc);
        chk("calc_lat", calc_rise - acc, 1);
        chk("done_lat", done_cyc - v, 9);
        chk("err_clean", 32'(err), 0);
        chk("cfg", {mode, xmode, act_en, dot_en, iq, wq, oq},
            {4'd1, 2'd1, 1'b1, 1'b0, 4'd3, 4'd2, 4'd1});
        tick();
        chk("done_pulse", 32'(done), 0);
        chk("cfg_hold", 32'(mode), 32'(MODE_CONV));

        // LUT load, back-to-back stream
        clr_mon();
        dc = done_cnt;
        send_cmd(MODE_FC, SIGMOID, 1, 0, 12'h456, 16'd1, 1, acc);
        stream_lut(16, 0, 24'h000100);
        repeat (2) tick();
        chk("lut_n", we_cnt, 16);
        chk("lut_first", first_we - acc, 2);
        chk("lut_consec", last_we - first_we, 15);
        chk("lut_calc", calc_rise - last_we, 1);
        pulse_vld(v);
        wait_done(dc);
        chk("lut_sb_empty", sb.size(), 0);

        // LUT load, stream valid every other cycle
        clr_mon();
        dc = done_cnt;
        send_cmd(MODE_POOL, TANH, 1, 0, 12'h777, 16'd1, 1, acc);
        stream_lut(16, 1, 24'h00A5A0);
        repeat (3) tick();
        chk("tog_n", we_cnt, 16);
        chk("tog_sb_empty", sb.size(), 0);
        pulse_vld(v);
        wait_done(dc);

        // Overrun: third valid lands in drain
        clr_mon();
        dc = done_cnt;
        send_cmd(MODE_DOTACC, NOACT, 0, 1, 12'h9AB, 16'd2, 0, acc);
        tick();
        pulse_vld(v);
        repeat (2) tick();
        pulse_vld(v2);
        chk("ovr_no_err", 32'(err), 0);
        tick();
        pulse_vld(v);
        chk("ovr_err", 32'(err), 1);
        wait_done(dc);
        chk("ovr_done_lat", done_cyc - v2, 9);
        chk("ovr_cfg", {mode, dot_en, act_en},
            {MODE_DOTACC, 1'b1, 1'b0});
        tick();
        chk("err_sticky", 32'(err), 1);

        // Zero-count layer: straight to drain
        clr_mon();
        dc = done_cnt;
        send_cmd(MODE_ADD, NOACT, 0, 0, 12'h000, 16'd0, 0, acc);
        chk("err_clr", 32'(err), 0);
        wait_done(dc);
        chk("zero_lat", done_cyc - acc, 9);
        chk("zero_calc", calc_rise, -1);

        // Reset after the 5th LUT write
        clr_mon();
        send_cmd(MODE_MATRIX, RELU, 1, 1, 12'hFED, 16'd3, 1, acc);
        stream_lut(5, 0, 24'h0000A0);
        tick();
        chk("pre_rst_n", we_cnt, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {mode, xmode, act_en, dot_en, iq, wq, oq,
                             calc_en, lut_we, lut_en, busy, done,
                             err}, 0);
        chk("mid_rst_lut", {lut_wdata, lut_addr}, 0);
        tick();
        rst_n = 1'b1;
        sb.delete();
        tick();
        chk("post_rst_rdy", {cmd_rdy, lut_rdy, busy}, 3'b100);

        clr_mon();
        dc = done_cnt;
        send_cmd(MODE_AVG_POOL, NOACT, 0, 0, 12'h123, 16'd1, 0, acc);
        tick();
        pulse_vld(v);
        wait_done(dc);
        chk("post_calc", calc_rise - acc, 1);
        chk("post_done", done_cyc - v, 9);
        chk("post_err", 32'(err), 0);
        chk("post_mode", 32'(mode), 32'(MODE_AVG_POOL));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
